// File: rtl/nbldpc_ctrl_pkg.sv
// Shared sequencing constants and state encoding for the GF16 NB-LDPC decoder control path.
// latency: n/a; backpressure: n/a.
package nbldpc_ctrl_pkg;

    localparam int COUNT_LEN_DEF = 13;
    localparam int N_COLS_DEF    = 384;
    localparam int N_ROWS_DEF    = 192;
    localparam int DC_LOG2_DEF   = 2;
    localparam int MAX_ITER_DEF  = 10;
    localparam int ITER_LEN_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PREP,
        DECODE,
        CHECK,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/iteration_controller.sv
// Decoder sequencer: drives counter_block and maps its count to LLR load / check-edge addresses.
// latency: addresses are combinational from count, controls are registered; backpressure: none, CHECK waits on syndrome_valid.
module iteration_controller
    import nbldpc_ctrl_pkg::*;
#(
    parameter int COUNT_LEN = COUNT_LEN_DEF,
    parameter int N_COLS    = N_COLS_DEF,
    parameter int N_ROWS    = N_ROWS_DEF,
    parameter int DC_LOG2   = DC_LOG2_DEF,
    parameter int MAX_ITER  = MAX_ITER_DEF,
    parameter int ITER_LEN  = ITER_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [COUNT_LEN-1:0]         count,
    input  logic                         syndrome_valid,
    input  logic                         syndrome_ok,
    output logic                         cnt_enable,
    output logic                         cnt_clear,
    output logic                         load_we,
    output logic [COUNT_LEN-1:0]         load_addr,
    output logic                         edge_valid,
    output logic [COUNT_LEN-DC_LOG2-1:0] row_addr,
    output logic [DC_LOG2-1:0]           edge_idx,
    output logic                         last_edge,
    output logic [ITER_LEN-1:0]          iter,
    output logic                         busy,
    output logic                         done,
    output logic                         converged
);

    localparam int DC          = 1 << DC_LOG2;
    localparam int LAST_EDGE_I = N_ROWS * DC - 1;

    localparam logic [COUNT_LEN-1:0] LAST_LOAD = COUNT_LEN'(N_COLS - 1);
    localparam logic [COUNT_LEN-1:0] LAST_EDGE = COUNT_LEN'(LAST_EDGE_I);
    localparam logic [ITER_LEN-1:0]  LAST_ITER = ITER_LEN'(MAX_ITER - 1);

    if (LAST_EDGE_I >= (1 << COUNT_LEN) || (N_COLS - 1) >= (1 << COUNT_LEN) ||
        MAX_ITER < 1 || MAX_ITER > (1 << ITER_LEN)) begin : g_param_check
        $error("iteration_controller: parameters do not fit COUNT_LEN/ITER_LEN");
    end

    ctrl_state_t         state_q, state_d;
    logic [ITER_LEN-1:0] iter_q, iter_d;
    logic                converged_q, converged_d;
    logic                cnt_enable_q, cnt_enable_d;
    logic                cnt_clear_q, cnt_clear_d;
    logic                load_we_q, load_we_d;
    logic                edge_valid_q, edge_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        converged_d = converged_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    iter_d      = '0;
                    converged_d = 1'b0;
                end
            end
            LOAD: begin
                if (count == LAST_LOAD) state_d = PREP;
            end
            PREP: begin
                state_d = DECODE;
                iter_d  = '0;
            end
            DECODE: begin
                if (count == LAST_EDGE) state_d = CHECK;
            end
            CHECK: begin
                if (syndrome_valid) begin
                    if (syndrome_ok) begin
                        converged_d = 1'b1;
                        state_d     = DONE;
                    end else if (iter_q == LAST_ITER) begin
                        converged_d = 1'b0;
                        state_d     = DONE;
                    end else begin
                        iter_d  = iter_q + ITER_LEN'(1);
                        state_d = DECODE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Controls are registered from next-state so the async counter clear never glitches.
        cnt_enable_d = (state_d == LOAD) || (state_d == DECODE);
        cnt_clear_d  = !cnt_enable_d;
        load_we_d    = (state_d == LOAD);
        edge_valid_d = (state_d == DECODE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            iter_q       <= '0;
            converged_q  <= 1'b0;
            cnt_enable_q <= 1'b0;
            cnt_clear_q  <= 1'b1;
            load_we_q    <= 1'b0;
            edge_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_q       <= iter_d;
            converged_q  <= converged_d;
            cnt_enable_q <= cnt_enable_d;
            cnt_clear_q  <= cnt_clear_d;
            load_we_q    <= load_we_d;
            edge_valid_q <= edge_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cnt_enable = cnt_enable_q;
    assign cnt_clear  = cnt_clear_q;
    assign load_we    = load_we_q;
    assign load_addr  = count;
    assign edge_valid = edge_valid_q;
    assign row_addr   = count[COUNT_LEN-1:DC_LOG2];
    assign edge_idx   = count[DC_LOG2-1:0];
    assign last_edge  = edge_valid_q && (count == LAST_EDGE);
    assign iter       = iter_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign converged  = converged_q;

endmodule

// File: tb/tb_iteration_controller.sv
// Bench for iteration_controller with a behavioural counter_block and a trace-based reference.
module tb_iteration_controller;

    localparam int CL = 13;
    localparam int NC = 8;
    localparam int NR = 4;
    localparam int DL = 2;
    localparam int MI = 3;
    localparam int IL = 4;
    localparam int DC = 1 << DL;
    localparam int NE = NR * DC;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic syndrome_valid = 1'b0;
    logic syndrome_ok = 1'b0;
    logic [CL-1:0] count = '0;

    logic           cnt_enable, cnt_clear, load_we, edge_valid, last_edge;
    logic           busy, done, converged;
    logic [CL-1:0]  load_addr;
    logic [CL-DL-1:0] row_addr;
    logic [DL-1:0]  edge_idx;
    logic [IL-1:0]  iter;

    always #5 clk = ~clk;

    // counter_block stand-in: asynchronous clear, synchronous enable.
    always @(posedge clk or posedge cnt_clear) begin
        if (cnt_clear) count <= '0;
        else if (cnt_enable) count <= count + CL'(1);
    end

    iteration_controller #(
        .COUNT_LEN(CL), .N_COLS(NC), .N_ROWS(NR), .DC_LOG2(DL), .MAX_ITER(MI), .ITER_LEN(IL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .syndrome_valid(syndrome_valid), .syndrome_ok(syndrome_ok),
        .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .load_we(load_we),
        .load_addr(load_addr), .edge_valid(edge_valid), .row_addr(row_addr),
        .edge_idx(edge_idx), .last_edge(last_edge), .iter(iter), .busy(busy),
        .done(done), .converged(converged)
    );

    // One entry per clock: inputs applied this cycle plus outputs expected this cycle.
    typedef struct {
        bit rst; bit start; bit sv; bit sok;
        bit clr; bit en; bit we; bit ev; bit last; bit busy; bit done; bit conv;
        bit chk_iter; int cnt; int iter;
    } vec_t;

    vec_t trace[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   prev_iter = 0;
    bit   prev_conv = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic vec_t blank();
        vec_t v;
        v = '{default: 0};
        return v;
    endfunction

    task automatic push_idle(input bit with_start);
        vec_t v;
        v = blank();
        v.start = with_start;
        v.sv = rnd_bit();
        v.sok = rnd_bit();
        v.clr = 1'b1;
        v.chk_iter = 1'b1;
        v.iter = prev_iter;
        v.conv = prev_conv;
        trace.push_back(v);
    endtask

    // ok_at: iteration whose syndrome passes (-1 = never); abort_*: where reset hits (-1 = none).
    task automatic build_run(input int ok_at, input int abort_iter, input int abort_edge);
        vec_t v;
        int iters;
        int w;
        iters = (ok_at >= 0) ? ok_at + 1 : MI;
        push_idle(1'b1);
        for (int a = 0; a < NC; a++) begin
            v = blank();
            v.start = rnd_bit(); v.sv = rnd_bit(); v.sok = rnd_bit();
            v.en = 1'b1; v.we = 1'b1; v.cnt = a; v.busy = 1'b1;
            trace.push_back(v);
        end
        v = blank();
        v.start = rnd_bit(); v.sv = rnd_bit(); v.sok = rnd_bit();
        v.clr = 1'b1; v.busy = 1'b1; v.chk_iter = 1'b1; v.iter = 0;
        trace.push_back(v);
        for (int it = 0; it < iters; it++) begin
            for (int e = 0; e < NE; e++) begin
                v = blank();
                v.start = rnd_bit(); v.sv = rnd_bit(); v.sok = rnd_bit();
                v.en = 1'b1; v.ev = 1'b1; v.cnt = e; v.last = (e == NE - 1);
                v.busy = 1'b1; v.chk_iter = 1'b1; v.iter = it;
                if (it == abort_iter && e == abort_edge) begin
                    v.rst = 1'b1;
                    trace.push_back(v);
                    prev_iter = 0;
                    prev_conv = 1'b0;
                    push_idle(1'b0);
                    return;
                end
                trace.push_back(v);
            end
            w = int'($urandom_range(0, 3));
            for (int k = 0; k <= w; k++) begin
                v = blank();
                v.start = rnd_bit();
                v.sv = (k == w);
                v.sok = (k == w) ? (it == ok_at) : rnd_bit();
                v.clr = 1'b1; v.busy = 1'b1; v.chk_iter = 1'b1; v.iter = it;
                trace.push_back(v);
            end
        end
        v = blank();
        v.start = rnd_bit(); v.sv = rnd_bit(); v.sok = rnd_bit();
        v.clr = 1'b1; v.busy = 1'b1; v.done = 1'b1;
        v.chk_iter = 1'b1; v.iter = iters - 1; v.conv = (ok_at >= 0);
        trace.push_back(v);
        prev_iter = iters - 1;
        prev_conv = (ok_at >= 0);
        push_idle(1'b0);
    endtask

    task automatic apply_all();
        vec_t v;
        while (trace.size() > 0) begin
            v = trace.pop_front();
            @(posedge clk);
            #1;
            reset = v.rst;
            start = v.start;
            syndrome_valid = v.sv;
            syndrome_ok = v.sok;
            @(negedge clk);
            check("cnt_clear",  int'(cnt_clear),  int'(v.clr));
            check("cnt_enable", int'(cnt_enable), int'(v.en));
            check("load_we",    int'(load_we),    int'(v.we));
            check("load_addr",  int'(load_addr),  v.cnt);
            check("edge_valid", int'(edge_valid), int'(v.ev));
            check("row_addr",   int'(row_addr),   v.cnt / DC);
            check("edge_idx",   int'(edge_idx),   v.cnt % DC);
            check("last_edge",  int'(last_edge),  int'(v.last));
            check("busy",       int'(busy),       int'(v.busy));
            check("done",       int'(done),       int'(v.done));
            check("converged",  int'(converged),  int'(v.conv));
            if (v.chk_iter) check("iter", int'(iter), v.iter);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cnt_clear",  int'(cnt_clear),  1);
        check("rst_cnt_enable", int'(cnt_enable), 0);
        check("rst_load_we",    int'(load_we),    0);
        check("rst_edge_valid", int'(edge_valid), 0);
        check("rst_last_edge",  int'(last_edge),  0);
        check("rst_busy",       int'(busy),       0);
        check("rst_done",       int'(done),       0);
        check("rst_iter",       int'(iter),       0);
        check("rst_converged",  int'(converged),  0);

        build_run(0, -1, -1);
        build_run(-1, -1, -1);
        build_run(-1, 1, 7);
        build_run(1, -1, -1);
        build_run(2, -1, -1);
        for (int r = 0; r < 8; r++) begin
            build_run(int'($urandom_range(0, MI)) - 1, -1, -1);
        end
        apply_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
